// File: rtl/truth_table_checker.sv
// -----------------------------------------------------------------------------
// truth_table_checker
//
// Purpose:
//   Exhaustive response checker for a small combinational block. On a start
//   pulse it walks every input vector of an N_IN-input function, holds each
//   vector for SETTLE cycles, samples the block's output, and compares it with
//   a golden truth table. Results stay registered so they can drive board
//   LEDs or be read by a testbench.
//
// Parameters:
//   N_IN      number of inputs of the block under test (1..6)
//   EXPECTED  golden truth table, bit i = expected output for vector i
//   SETTLE    cycles a vector is held before sampling (1..15)
//
// Ports:
//   clk         in   system clock, rising edge
//   reset       in   synchronous active-high reset
//   start       in   one-cycle pulse, starts a sweep when idle or done
//   vec         out  vector driven to the block, MSB = first input
//   y_dut       in   output of the block under test
//   busy        out  sweep in progress
//   done        out  sweep finished, held until next accepted start/reset
//   pass        out  no mismatches (meaningful when done=1)
//   err_count   out  number of mismatching vectors
//   first_fail  out  lowest mismatching vector index
//   fail_seen   out  at least one mismatch recorded
//   observed    out  sampled output per vector, bit i = y for vector i
// -----------------------------------------------------------------------------
module truth_table_checker #(
    parameter int                    N_IN     = 3,
    parameter logic [2**N_IN-1:0]    EXPECTED = 8'h31,
    parameter int                    SETTLE   = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    output logic [N_IN-1:0]      vec,
    input  logic                 y_dut,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [N_IN:0]        err_count,
    output logic [N_IN-1:0]      first_fail,
    output logic                 fail_seen,
    output logic [2**N_IN-1:0]   observed
);

    localparam int              N_VEC         = 2**N_IN;
    localparam logic [N_IN-1:0] LAST_VEC      = N_IN'(N_VEC - 1);
    localparam logic [3:0]      SETTLE_RELOAD = 4'(SETTLE - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_CHECK,
        S_DONE
    } state_t;

    state_t              r_state;
    state_t              w_state_next;

    logic [N_IN-1:0]     r_vec;
    logic [3:0]          r_settle_cnt;
    logic                r_busy;
    logic                r_done;
    logic                r_pass;
    logic [N_IN:0]       r_err_count;
    logic [N_IN-1:0]     r_first_fail;
    logic                r_fail_seen;
    logic [N_VEC-1:0]    r_observed;

    logic                w_accept;
    logic                w_expected;
    logic                w_mismatch;
    logic                w_last;
    logic [N_IN:0]       w_err_next;

    // A start is only honoured when no sweep is running; pulses while busy
    // are dropped so they cannot disturb the sweep timing.
    assign w_accept   = start && ((r_state == S_IDLE) || (r_state == S_DONE));

    // The comparison is purely combinational so the result of the current
    // vector can be folded into the error count in the same edge that
    // leaves CHECK; this is why pass can include the last vector.
    assign w_expected = EXPECTED[r_vec];
    assign w_mismatch = (y_dut != w_expected);
    assign w_last     = (r_vec == LAST_VEC);
    assign w_err_next = r_err_count + {{N_IN{1'b0}}, w_mismatch};

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic. IDLE and DONE behave identically on start, so a
    // finished sweep can be rerun without an intervening reset.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    w_state_next = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (r_settle_cnt == 4'd0) begin
                    w_state_next = S_CHECK;
                end
            end
            S_CHECK: begin
                if (w_last) begin
                    w_state_next = S_DONE;
                end else begin
                    w_state_next = S_SETTLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Datapath: vector sequencing, settle timing and result capture.
    // A sweep clears every result register at the accepting edge, so results
    // from an older sweep never leak into a new one. vec stops at the last
    // vector instead of wrapping, leaving the final vector visible in DONE.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_vec        <= '0;
            r_settle_cnt <= 4'd0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_pass       <= 1'b0;
            r_err_count  <= '0;
            r_first_fail <= '0;
            r_fail_seen  <= 1'b0;
            r_observed   <= '0;
        end else if (w_accept) begin
            r_vec        <= '0;
            r_settle_cnt <= SETTLE_RELOAD;
            r_busy       <= 1'b1;
            r_done       <= 1'b0;
            r_pass       <= 1'b0;
            r_err_count  <= '0;
            r_first_fail <= '0;
            r_fail_seen  <= 1'b0;
            r_observed   <= '0;
        end else begin
            case (r_state)
                S_SETTLE: begin
                    if (r_settle_cnt != 4'd0) begin
                        r_settle_cnt <= r_settle_cnt - 4'd1;
                    end
                end
                S_CHECK: begin
                    r_observed[r_vec] <= y_dut;
                    r_err_count       <= w_err_next;
                    if (w_mismatch && !r_fail_seen) begin
                        r_first_fail <= r_vec;
                        r_fail_seen  <= 1'b1;
                    end
                    if (w_last) begin
                        r_busy <= 1'b0;
                        r_done <= 1'b1;
                        r_pass <= (w_err_next == '0);
                    end else begin
                        r_vec        <= r_vec + 1'b1;
                        r_settle_cnt <= SETTLE_RELOAD;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign vec        = r_vec;
    assign busy       = r_busy;
    assign done       = r_done;
    assign pass       = r_pass;
    assign err_count  = r_err_count;
    assign first_fail = r_first_fail;
    assign fail_seen  = r_fail_seen;
    assign observed   = r_observed;

endmodule

// File: tb/tb_truth_table_checker.sv
// -----------------------------------------------------------------------------
// tb_truth_table_checker
//
// Purpose:
//   Drives two checker instances (default SETTLE=1 and SETTLE=3) against
//   several models of sillyfunction: ideal, stuck-at-0, stuck-at-1 and a
//   version whose output lags its inputs by two clock cycles. Expected
//   sweep results are hand-computed and queued when a sweep is started; a
//   monitor per instance pops and compares them when done rises.
// -----------------------------------------------------------------------------
module tb_truth_table_checker;

    typedef struct {
        string      tag;
        logic [3:0] err;
        logic [2:0] ff;
        logic       fs;
        logic       ps;
        logic [7:0] obs;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       startA, startB;
    logic       yA, yB;
    logic [2:0] vecA, vecB;
    logic       busyA, busyB, doneA, doneB, passA, passB;
    logic [3:0] errA, errB;
    logic [2:0] ffA, ffB;
    logic       fsA, fsB;
    logic [7:0] obsA, obsB;

    logic       dA1, dA2, dB1, dB2;
    logic       doneAq = 1'b0;
    logic       doneBq = 1'b0;

    int         modeA = 0;
    int         modeB = 0;
    int         sel   = 0;
    int         total = 0;
    int         bad   = 0;

    exp_t       qA[$];
    exp_t       qB[$];

    always #5 clk = ~clk;

    truth_table_checker dutA (
        .clk(clk), .reset(reset), .start(startA), .vec(vecA), .y_dut(yA),
        .busy(busyA), .done(doneA), .pass(passA), .err_count(errA),
        .first_fail(ffA), .fail_seen(fsA), .observed(obsA)
    );

    truth_table_checker #(.SETTLE(3)) dutB (
        .clk(clk), .reset(reset), .start(startB), .vec(vecB), .y_dut(yB),
        .busy(busyB), .done(doneB), .pass(passB), .err_count(errB),
        .first_fail(ffB), .fail_seen(fsB), .observed(obsB)
    );

    // Reference sillyfunction: y = ~b&~c | a&~b with vec = {a,b,c}.
    function automatic logic idealY(input logic [2:0] v);
        return (~v[1] & ~v[0]) | (v[2] & ~v[1]);
    endfunction

    // Two-cycle output lag model of the block under test.
    always @(posedge clk) begin
        dA1 <= idealY(vecA);
        dA2 <= dA1;
        dB1 <= idealY(vecB);
        dB2 <= dB1;
    end

    // Block-under-test selection: 0 ideal, 1 stuck-at-0, 2 stuck-at-1, 3 lagged.
    always_comb begin
        yA = 1'b0;
        case (modeA)
            0: yA = idealY(vecA);
            1: yA = 1'b0;
            2: yA = 1'b1;
            default: yA = dA2;
        endcase
        yB = 1'b0;
        case (modeB)
            0: yB = idealY(vecB);
            1: yB = 1'b0;
            2: yB = 1'b1;
            default: yB = dB2;
        endcase
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    task automatic compareResult(input exp_t e, input logic [3:0] err,
                                 input logic [2:0] ff, input logic fs,
                                 input logic ps, input logic [7:0] obs);
        checkOutput({e.tag, "_err_count"}, 32'(err), 32'(e.err));
        checkOutput({e.tag, "_fail_seen"}, 32'(fs),  32'(e.fs));
        checkOutput({e.tag, "_first_fail"}, 32'(ff), 32'(e.ff));
        checkOutput({e.tag, "_pass"},      32'(ps),  32'(e.ps));
        checkOutput({e.tag, "_observed"},  32'(obs), 32'(e.obs));
    endtask

    // Monitors: compare the oldest queued expectation on every rising done.
    always @(negedge clk) begin
        if (doneA && !doneAq) begin
            if (qA.size() == 0) begin
                checkOutput("A_unexpected_done", 32'd1, 32'd0);
            end else begin
                compareResult(qA.pop_front(), errA, ffA, fsA, passA, obsA);
            end
        end
        doneAq <= doneA;
    end

    always @(negedge clk) begin
        if (doneB && !doneBq) begin
            if (qB.size() == 0) begin
                checkOutput("B_unexpected_done", 32'd1, 32'd0);
            end else begin
                compareResult(qB.pop_front(), errB, ffB, fsB, passB, obsB);
            end
        end
        doneBq <= doneB;
    end

    // Pulse start on the selected instance; returns just after the accepting edge.
    task automatic applyStimulus();
        @(negedge clk);
        if (sel == 1) startB = 1'b1; else startA = 1'b1;
        @(posedge clk);
        #1;
        startA = 1'b0;
        startB = 1'b0;
        checkOutput("busy_after_start", 32'(sel == 1 ? busyB : busyA), 32'd1);
        checkOutput("done_after_start", 32'(sel == 1 ? doneB : doneA), 32'd0);
    endtask

    // Count edges from the accepting edge until done, optionally poking start
    // mid-sweep and checking the vec sequence of instance A.
    task automatic waitDone(input int expEdges, input bit chkVec,
                            input int poke1, input int poke2);
        int  n = 0;
        logic d;
        while (1) begin
            d = (sel == 1) ? doneB : doneA;
            if (chkVec && n < 16) begin
                checkOutput($sformatf("vec_at_edge_%0d", n), 32'(vecA), 32'(n / 2));
            end
            if (d || n >= 200) break;
            if (sel == 1) startB = (n == poke1) || (n == poke2);
            else          startA = (n == poke1) || (n == poke2);
            @(posedge clk);
            #1;
            n++;
        end
        startA = 1'b0;
        startB = 1'b0;
        checkOutput("done_latency", 32'(n), 32'(expEdges));
        checkOutput("busy_at_done", 32'(sel == 1 ? busyB : busyA), 32'd0);
    endtask

    initial begin
        reset  = 1'b1;
        startA = 1'b0;
        startB = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_vec",        32'(vecA), 32'd0);
        checkOutput("rst_busy",       32'(busyA), 32'd0);
        checkOutput("rst_done",       32'(doneA), 32'd0);
        checkOutput("rst_pass",       32'(passA), 32'd0);
        checkOutput("rst_err_count",  32'(errA), 32'd0);
        checkOutput("rst_first_fail", 32'(ffA), 32'd0);
        checkOutput("rst_fail_seen",  32'(fsA), 32'd0);
        checkOutput("rst_observed",   32'(obsA), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Ideal block, then stuck-at-0 and stuck-at-1 with vec stepping check.
        sel = 0;
        modeA = 0;
        qA.push_back('{"ideal", 4'd0, 3'd0, 1'b0, 1'b1, 8'h31});
        applyStimulus();
        waitDone(16, 1'b0, -1, -1);

        modeA = 1;
        qA.push_back('{"tie0", 4'd3, 3'd0, 1'b1, 1'b0, 8'h00});
        applyStimulus();
        waitDone(16, 1'b0, -1, -1);

        modeA = 2;
        qA.push_back('{"tie1", 4'd5, 3'd1, 1'b1, 1'b0, 8'hFF});
        applyStimulus();
        waitDone(16, 1'b1, -1, -1);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("vec_held_in_done", 32'(vecA), 32'd7);
        checkOutput("done_held",        32'(doneA), 32'd1);

        // Restart from DONE with start pokes in SETTLE (edge 3) and CHECK (edge 4).
        modeA = 0;
        qA.push_back('{"restart", 4'd0, 3'd0, 1'b0, 1'b1, 8'h31});
        applyStimulus();
        waitDone(16, 1'b0, 2, 3);

        // Reset while vec=4 aborts the sweep, then a fresh sweep passes.
        applyStimulus();
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (vecA == 3'd4) break;
        end
        checkOutput("reached_vec4", 32'(vecA), 32'd4);
        reset = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("abort_vec",        32'(vecA), 32'd0);
        checkOutput("abort_busy",       32'(busyA), 32'd0);
        checkOutput("abort_err_count",  32'(errA), 32'd0);
        checkOutput("abort_observed",   32'(obsA), 32'd0);
        checkOutput("abort_fail_seen",  32'(fsA), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        qA.push_back('{"after_abort", 4'd0, 3'd0, 1'b0, 1'b1, 8'h31});
        applyStimulus();
        waitDone(16, 1'b0, -1, -1);

        // Lagged block with SETTLE=1: sample k sees ideal(k-1), ideal(0) for k=0.
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        modeA = 3;
        qA.push_back('{"lag_s1", 4'd3, 3'd1, 1'b1, 1'b0, 8'h63});
        applyStimulus();
        waitDone(16, 1'b0, -1, -1);

        // SETTLE=3 instance: ideal and lagged both pass, 32-edge sweep.
        sel = 1;
        modeB = 0;
        qB.push_back('{"s3_ideal", 4'd0, 3'd0, 1'b0, 1'b1, 8'h31});
        applyStimulus();
        waitDone(32, 1'b0, -1, -1);

        modeB = 3;
        qB.push_back('{"s3_lag", 4'd0, 3'd0, 1'b0, 1'b1, 8'h31});
        applyStimulus();
        waitDone(32, 1'b0, -1, -1);

        @(negedge clk);
        #1;
        checkOutput("queueA_drained", 32'(qA.size()), 32'd0);
        checkOutput("queueB_drained", 32'(qB.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
